// File: rtl/sigdelay_pkg.sv
// Shared types and helpers for the signal-generator delay reader.
//   sd_state_t : fill/run state of the readout FSM
//   max_off()  : largest delay (in samples) whose address span still fits
//                inside a 2^aw deep buffer when addresses step by 'step'
package sigdelay_pkg;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } sd_state_t;

   function automatic int max_off(input int aw, input int step);
      return ((1 << aw) - 1) / step;
   endfunction

endpackage

// File: rtl/ram2port.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read
// port. Read-first: a read of the address being written returns old data.
// Ports:
//   clk_i               clock
//   we_i, waddr_i, wdata_i   write port
//   re_i, raddr_i, rdata_o   read port (registered data, 1-cycle latency)
module ram2port #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [0:(1<<AW)-1];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sig_delay_reader.sv
// Read side of the signal-generator sample buffer. Each enabled cycle the
// current sample is written at wr_addr_i and the sample written off_eff
// enables earlier is read back, giving a delayed copy of the waveform.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   en_i              sample strobe (same as address counter enable)
//   wr_addr_i         current address counter value
//   wr_data_i         sample stored at wr_addr_i
//   offset_i          requested delay in samples (clamped to MAX_OFF)
//   dout_o            delayed sample, held while dout_valid_o is low
//   dout_valid_o      one pulse per valid read, 1 cycle after en_i
//   rd_addr_o         registered read address (debug)
//   primed_o          high while in RUN
//
// state | meaning
// FILL  | history shorter than the delay, reads not yet valid
// RUN   | enough history, every enabled read is valid
module sig_delay_reader
   import sigdelay_pkg::*;
#(
   parameter int AW   = 8,
   parameter int DW   = 8,
   parameter int STEP = 3
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic [AW-1:0] offset_i,
   output logic [DW-1:0] dout_o,
   output logic          dout_valid_o,
   output logic [AW-1:0] rd_addr_o,
   output logic          primed_o
);

   localparam logic [AW-1:0] MAX_OFF = AW'(max_off(AW, STEP));
   localparam logic [AW+1:0] STEP_W  = (AW+2)'(STEP);

   sd_state_t     state_q, state_d;
   logic [AW-1:0] off_eff, off_q, off_d;
   logic [AW-1:0] fill_cnt_q, fill_cnt_d;
   logic [AW-1:0] rd_addr, rd_addr_q;
   logic [AW+1:0] off_prod;
   logic          off_chg, we;
   logic          valid_q, valid_d;
   logic          byp_q;
   logic [DW-1:0] wdat_q, dout_hold_q, ram_rdata, dout_cur;

   assign off_eff  = (offset_i > MAX_OFF) ? MAX_OFF : offset_i;
   assign off_prod = {2'b00, off_eff} * STEP_W;
   assign rd_addr  = wr_addr_i - off_prod[AW-1:0];
   assign off_chg  = (off_eff != off_q);
   assign we       = en_i & ~rst_i;

   ram2port #(.AW(AW), .DW(DW)) u_ram (
      .clk_i   (clk_i),
      .we_i    (we),
      .waddr_i (wr_addr_i),
      .wdata_i (wr_data_i),
      .re_i    (we),
      .raddr_i (rd_addr),
      .rdata_o (ram_rdata)
   );

   // '>=' rather than '==': a delay change to 0 coinciding with an enable
   // enters FILL with fill_cnt already at 1, which must still qualify.
   always_comb begin
      state_d    = state_q;
      off_d      = off_q;
      fill_cnt_d = fill_cnt_q;
      valid_d    = 1'b0;
      if (off_chg) begin
         state_d    = FILL;
         off_d      = off_eff;
         fill_cnt_d = en_i ? AW'(1) : '0;
      end else if (en_i) begin
         case (state_q)
            FILL: begin
               fill_cnt_d = fill_cnt_q + AW'(1);
               if (fill_cnt_q >= off_q) begin
                  valid_d = 1'b1;
                  state_d = RUN;
               end
            end
            RUN:     valid_d = 1'b1;
            default: state_d = FILL;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= FILL;
         off_q       <= off_eff;
         fill_cnt_q  <= '0;
         valid_q     <= 1'b0;
         rd_addr_q   <= '0;
         byp_q       <= 1'b0;
         wdat_q      <= '0;
         dout_hold_q <= '0;
      end else begin
         state_q     <= state_d;
         off_q       <= off_d;
         fill_cnt_q  <= fill_cnt_d;
         valid_q     <= valid_d;
         dout_hold_q <= dout_o;
         if (en_i) begin
            rd_addr_q <= rd_addr;
            byp_q     <= (rd_addr == wr_addr_i);
            wdat_q    <= wr_data_i;
         end
      end
   end

   // RAM is read-first; a same-address read takes the fresh write data.
   assign dout_cur     = byp_q ? wdat_q : ram_rdata;
   assign dout_o       = valid_q ? dout_cur : dout_hold_q;
   assign dout_valid_o = valid_q;
   assign rd_addr_o    = rd_addr_q;
   assign primed_o     = (state_q == RUN);

endmodule

// File: tb/tb_sig_delay_reader.sv
module tb_sig_delay_reader;

   logic       clk_i = 1'b0;
   logic       rst_i, en_i;
   logic [7:0] wr_addr_i, wr_data_i, offset_i;
   logic [7:0] dout_o, rd_addr_o;
   logic       dout_valid_o, primed_o;

   sig_delay_reader #(.AW(8), .DW(8), .STEP(3)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .en_i         (en_i),
      .wr_addr_i    (wr_addr_i),
      .wr_data_i    (wr_data_i),
      .offset_i     (offset_i),
      .dout_o       (dout_o),
      .dout_valid_o (dout_valid_o),
      .rd_addr_o    (rd_addr_o),
      .primed_o     (primed_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: sample history indexed by enable count
   int hist[$];
   int waddr   = 0;
   int off_m   = 0;
   int since   = 0;
   bit primed_m = 0;
   bit vld_m   = 0;
   int dout_m  = 0;
   int rda_m   = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input bit e, input int off, input int data, input bit r);
      int  off_e;
      bit  chg;
      rst_i     = r;
      en_i      = e;
      offset_i  = 8'(off);
      wr_data_i = 8'(data);
      wr_addr_i = 8'(waddr);
      @(posedge clk_i);
      off_e = (off > 85) ? 85 : off;
      if (r) begin
         off_m = off_e; since = 0; primed_m = 0; vld_m = 0; dout_m = 0; rda_m = 0;
      end else begin
         chg   = (off_e != off_m);
         vld_m = 0;
         if (e) begin
            hist.push_back(data & 255);
            if (!chg && since >= off_m) begin
               vld_m  = 1;
               dout_m = hist[hist.size() - 1 - off_m];
            end
            rda_m = (waddr - off_e * 3) & 255;
            waddr = (waddr + 3) & 255;
         end
         if (chg) begin
            off_m = off_e; since = e ? 1 : 0; primed_m = 0;
         end else begin
            if (e) since++;
            if (vld_m) primed_m = 1;
         end
      end
      #1;
      chk("dout_valid", dout_valid_o, vld_m);
      chk("dout", dout_o, dout_m);
      chk("primed", primed_o, primed_m);
      chk("rd_addr", rd_addr_o, rda_m);
   endtask

   initial begin
      int offs[6];
      offs = '{0, 1, 4, 17, 85, 200};
      rst_i = 1; en_i = 0; offset_i = 0; wr_data_i = 0; wr_addr_i = 0;
      // reset / idle
      step(0, 4, 0, 1);
      step(0, 4, 0, 1);
      for (int i = 0; i < 10; i++) step(0, 4, $urandom_range(255), 0);
      // basic delay of 4
      for (int i = 0; i < 12; i++) step(1, 4, 10 + i, 0);
      // delay change in RUN
      for (int i = 0; i < 8; i++) step(1, 2, $urandom_range(255), 0);
      // zero delay, first enable bypassed
      step(0, 0, 0, 0);
      step(1, 0, 'hA5, 0);
      chk("zero_delay_dout", dout_o, 'hA5);
      for (int i = 0; i < 5; i++) step(1, 0, $urandom_range(255), 0);
      // clamp and wrap
      for (int i = 0; i < 300; i++) step(1, 200, $urandom_range(255), 0);
      chk("clamp_rd_addr", rd_addr_o, (waddr - 3 + 1) & 255);
      // gapped enable
      for (int i = 0; i < 40; i++) step(i[0], 4, $urandom_range(255), 0);
      for (int i = 0; i < 40; i++) step(1'($urandom_range(1)), 4, $urandom_range(255), 0);
      // reset during RUN, then refill
      step(1, 4, $urandom_range(255), 1);
      for (int i = 0; i < 20; i++) step(1, 4, $urandom_range(255), 0);
      // random mix with occasional delay changes and resets
      begin
         int cur = 4;
         for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(99) < 3) cur = offs[$urandom_range(5)];
            step(($urandom_range(3) != 0), cur, $urandom_range(255),
                 ($urandom_range(199) == 0));
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sig_delay_reader.md
# sig_delay_reader

Read side of the signal-generator sample buffer. The address counter steps `wr_addr` by `STEP` on every enabled cycle, and this block writes `wr_data` into an internal dual-port RAM at that address. In the same cycle it reads back the sample written `offset` enables earlier, which produces the delayed copy of the generated waveform. An internal fill/run state machine holds `dout_valid` low until enough history exists.

## Interface
- `AW`, default 8: address width; the RAM depth is 2^AW.
- `DW`, default 8: sample width.
- `STEP`, default 3: address increment per enabled cycle. Must equal the counter's increment.
- `clk` input, 1 bit: clock.
- `rst` input, 1 bit: reset. Synchronous, active-high. One clock; all state changes on the rising edge of `clk`.
- `en` input, 1 bit: sample strobe. Same signal that enables the address counter.
- `wr_addr` input, AW bits: current counter output.
- `wr_data` input, DW bits: sample to store at `wr_addr`.
- `offset` input, AW bits: delay in samples (enabled cycles).
- `dout` output, DW bits: delayed sample.
- `dout_valid` output, 1 bit: `dout` is updated and valid this cycle.
- `rd_addr` output, AW bits: registered read address, for debug.
- `primed` output, 1 bit: high in the RUN state.

## Operation
- `MAX_OFF` = floor((2^AW − 1) / STEP). For the defaults, `MAX_OFF` = 85.
- Effective delay `off_eff` = min(`offset`, `MAX_OFF`).
- Read address calculation:
  - rd = `wr_addr` − `off_eff`·`STEP`, taken modulo 2^AW.
  - The product is computed at AW+2 bits and truncated. Wrap-around of both addresses is natural.
- Write: on an `en` cycle, RAM[`wr_addr`] ← `wr_data`. There is no write without `en`.
- Read: on an `en` cycle, the RAM is read at rd and `rd_addr` ← rd.
- Read/write collision (rd == `wr_addr`, which only happens when `off_eff` = 0): the block behaves write-first, so `dout` = `wr_data`.
- `off_q` register:
  - Holds the `off_eff` value in use.
  - Loaded on reset exit and whenever `off_eff` ≠ `off_q`.
  - Any mismatch restarts FILL.
- `fill_cnt` (AW bits) counts `en` cycles since FILL entry.
- State machine:
  - FILL: `primed` = 0. On each `en`, `fill_cnt` increments. When an `en` occurs with `fill_cnt` == `off_q`, the state moves to RUN, and that same read is valid. With `off_q` = 0, the first `en` is already valid.
  - RUN: `primed` = 1. Each `en` produces a valid read.
  - RUN → FILL on an `offset` change (`fill_cnt` ← 0). RAM contents are kept, but readout is not valid until refilled.
- Simultaneous `en` and `offset` change: the write happens, but the read is invalid. The state enters FILL with `fill_cnt` = 1 if `en` is high, else 0, and `off_q` takes the new value.
- `dout` holds its last value when `dout_valid` = 0.

## Timing
- Reset values: `dout` = 0, `dout_valid` = 0, `rd_addr` = 0, `primed` = 0, state = FILL, `fill_cnt` = 0, `off_q` ← `off_eff`.
- RAM contents are not cleared by reset.
- Read latency is 1 cycle. With `en` at cycle N, `dout` and `dout_valid` update at edge N+1.
- `dout_valid` is a single-cycle pulse per qualifying `en`, so back-to-back `en` gives continuous valid.
- `rst` asserted mid-operation:
  - Takes effect at the next edge and overrides `en`. There is no write in a reset cycle.
  - FILL restarts after release.
- Throughput is one sample per cycle. There is no backpressure.

## Structure
- Package `sigdelay_pkg`:
  - State enum `sd_state_t` {FILL, RUN}.
  - Function `max_off(AW, STEP)`.
- Sub-module `ram2port` (parameters AW, DW):
  - One synchronous write port and one synchronous read port, read-first.
  - The write-first bypass mux lives in `sig_delay_reader`, not the RAM.
- The top level holds the FSM, `fill_cnt`, `off_q`, address arithmetic and bypass. Target size is about 150–250 lines total.

## Test plan
- **Reset/idle:** `rst` for 2 cycles, `en` = 0 → all outputs 0, no `dout_valid` for 10 cycles.
- **Basic delay:** `offset` = 4, `en` held high, `wr_addr` = 0, 3, 6, …, `wr_data` = 10, 11, 12, … → the first `dout_valid` follows the 5th `en`. On that cycle `rd_addr` = 0 and `dout` = 10, then 11, 12, … on consecutive cycles.
- **Zero delay:** `offset` = 0, `wr_data` = 0xA5 on the first `en` → next cycle `dout` = 0xA5, `dout_valid` = 1 (bypass).
- **Wrap and clamp:**
  - `offset` = 200 (clamped to 85), run for 300 `en` → `rd_addr` = `wr_addr` − 255 mod 256 = `wr_addr` + 1. `dout` equals the data written 85 `en` earlier across address wrap.
- **Offset change in RUN:** `offset` 4 → 2 while streaming → `dout_valid` drops on the next cycle. It reasserts after 2 further `en`, with 2-sample delayed data.
- **Gapped enable and mid-run reset:** toggle `en` 1/0 → `dout_valid` only follows `en`. Assert `rst` during RUN → `primed` = 0 the next cycle, and refill is required after release.
